// File: rtl/jump_resolve_pkg.sv
// jump_pkg: shared types and constants for the jump/branch resolve block.
//   state_e    - controller states
//   cmp_ctrl_e - branch comparison encodings (RISC-V funct3 values)
//   XLEN, REGW - datapath and register-index widths
//   jump_target() - effective target with the JALR bit0 clear applied
package jump_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESOLVE,
        S_WB,
        S_DRAIN
    } state_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'b000,
        CMP_BNE  = 3'b001,
        CMP_BLT  = 3'b100,
        CMP_BGE  = 3'b101,
        CMP_BLTU = 3'b110,
        CMP_BGEU = 3'b111
    } cmp_ctrl_e;

    function automatic logic [XLEN-1:0] jump_target(input logic            jalr,
                                                    input logic [XLEN-1:0] pc_jump);
        return {pc_jump[XLEN-1:1], pc_jump[0] & ~jalr};
    endfunction

endpackage

// File: rtl/jump_resolve_stats.sv
// jump_stats: resolve statistics counters (built only with JUMP_STATS_EN).
//   clk, rst_n       - clock, async active-low reset
//   resolve_i        - one pulse per completed RESOLVE cycle
//   taken_i          - that resolve was taken
//   stat_total_o     - count of resolves (wraps at 2^32)
//   stat_taken_o     - count of taken resolves (wraps at 2^32)
module jump_stats
    import jump_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            resolve_i,
    input  logic            taken_i,
    output logic [XLEN-1:0] stat_total_o,
    output logic [XLEN-1:0] stat_taken_o
);

    logic [XLEN-1:0] total_q;
    logic [XLEN-1:0] taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            taken_q <= '0;
        end else if (resolve_i) begin
            total_q <= total_q + 1'b1;
            if (taken_i) begin
                taken_q <= taken_q + 1'b1;
            end
        end
    end

    assign stat_total_o = total_q;
    assign stat_taken_o = taken_q;

endmodule

// File: rtl/jump_resolve.sv
// jump_resolve: sequences one jump/branch through the jump functional unit,
// resolves the target, redirects the front end and writes back the link value.
//   issue_*            - decode handshake and operands (latched on transfer)
//   fu_en, fu_*        - start pulse and held operand copies to the FU
//   fu_finish, fu_*res - FU results, captured in WAIT
//   wb_req/wb_grant    - writeback handshake with wb_rd/wb_data
//   redirect_*         - front-end redirect (RESOLVE cycle only)
//   misalign           - taken target with bit1 set
//   fu_timeout         - WAIT_MAX WAIT cycles without fu_finish
//   busy               - not IDLE
//   stat_total/taken   - resolve counters when JUMP_STATS_EN is defined, else 0
// Optional feature macro: JUMP_STATS_EN.
module jump_resolve
    import jump_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic            issue_jalr,
    input  logic            issue_branch,
    input  logic [2:0]      issue_cmp_ctrl,
    input  logic [REGW-1:0] issue_rd,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [XLEN-1:0] issue_rs2,
    input  logic [XLEN-1:0] issue_imm,
    input  logic [XLEN-1:0] issue_pc,
    output logic            fu_en,
    output logic            fu_jalr,
    output logic [2:0]      fu_cmp_ctrl,
    output logic [XLEN-1:0] fu_rs1,
    output logic [XLEN-1:0] fu_rs2,
    output logic [XLEN-1:0] fu_imm,
    output logic [XLEN-1:0] fu_pc,
    input  logic            fu_finish,
    input  logic            fu_cmp_res,
    input  logic [XLEN-1:0] fu_pc_jump,
    input  logic [XLEN-1:0] fu_pc_wb,
    output logic            wb_req,
    input  logic            wb_grant,
    output logic [REGW-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign,
    output logic            fu_timeout,
    output logic            busy,
    output logic [XLEN-1:0] stat_total,
    output logic [XLEN-1:0] stat_taken
);

    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            capture_res;

    logic            jalr_q, branch_q, cmp_res_q;
    logic [2:0]      cmp_q;
    logic [REGW-1:0] rd_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q, pc_jump_q, pc_wb_q;

    logic            taken;
    logic [XLEN-1:0] target;
    logic            target_mis;
    logic            cnt_last;

    assign taken      = ~branch_q | cmp_res_q;
    assign target     = jump_target(jalr_q, pc_jump_q);
    assign target_mis = taken & target[1];
    assign cnt_last   = (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jalr_q   <= 1'b0;
            branch_q <= 1'b0;
            cmp_q    <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else if (state_q == S_IDLE && issue_valid) begin
            jalr_q   <= issue_jalr;
            branch_q <= issue_branch;
            cmp_q    <= issue_cmp_ctrl;
            rd_q     <= issue_rd;
            rs1_q    <= issue_rs1;
            rs2_q    <= issue_rs2;
            imm_q    <= issue_imm;
            pc_q     <= issue_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_res_q <= 1'b0;
            pc_jump_q <= '0;
            pc_wb_q   <= '0;
        end else if (capture_res) begin
            cmp_res_q <= fu_cmp_res;
            pc_jump_q <= fu_pc_jump;
            pc_wb_q   <= fu_pc_wb;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        capture_res    = 1'b0;
        fu_en          = 1'b0;
        fu_timeout     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        misalign       = 1'b0;
        wb_req         = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (issue_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The FU is started even when flushed; DRAIN eats its finish.
                fu_en   = 1'b1;
                cnt_d   = '0;
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (fu_finish) begin
                    capture_res = 1'b1;
                    state_d     = S_RESOLVE;
                end else if (cnt_last) begin
                    fu_timeout = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
                if (!flush) begin
                    redirect_valid = taken & ~target[1];
                    redirect_pc    = target;
                    misalign       = target_mis;
                    if (!branch_q && rd_q != '0 && !target_mis) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                // A grant coinciding with flush still completes the write.
                wb_req  = 1'b1;
                wb_rd   = rd_q;
                wb_data = pc_wb_q;
                if (wb_grant || flush) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Bounded like WAIT so a lost finish cannot wedge the block.
                if (fu_finish || cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign issue_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign fu_jalr     = jalr_q;
    assign fu_cmp_ctrl = cmp_q;
    assign fu_rs1      = rs1_q;
    assign fu_rs2      = rs2_q;
    assign fu_imm      = imm_q;
    assign fu_pc       = pc_q;

`ifdef JUMP_STATS_EN
    // Only resolves that actually present their outcome are counted.
    logic resolve_fire;
    assign resolve_fire = (state_q == S_RESOLVE) && !flush;

    jump_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .resolve_i   (resolve_fire),
        .taken_i     (taken),
        .stat_total_o(stat_total),
        .stat_taken_o(stat_taken)
    );
`else
    assign stat_total = '0;
    assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_jump_resolve.sv
module tb_jump_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        issue_jalr = 1'b0;
    logic        issue_branch = 1'b0;
    logic [2:0]  issue_cmp_ctrl = 3'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic [31:0] issue_rs1 = 32'd0, issue_rs2 = 32'd0, issue_imm = 32'd0, issue_pc = 32'd0;
    logic        fu_en, fu_jalr;
    logic [2:0]  fu_cmp_ctrl;
    logic [31:0] fu_rs1, fu_rs2, fu_imm, fu_pc;
    logic        fu_finish = 1'b0;
    logic        fu_cmp_res = 1'b0;
    logic [31:0] fu_pc_jump = 32'd0, fu_pc_wb = 32'd0;
    logic        wb_req;
    logic        wb_grant = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign, fu_timeout, busy;
    logic [31:0] stat_total, stat_taken;

    jump_resolve #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_jalr(issue_jalr), .issue_branch(issue_branch),
        .issue_cmp_ctrl(issue_cmp_ctrl), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_imm(issue_imm), .issue_pc(issue_pc),
        .fu_en(fu_en), .fu_jalr(fu_jalr), .fu_cmp_ctrl(fu_cmp_ctrl),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_imm(fu_imm), .fu_pc(fu_pc),
        .fu_finish(fu_finish), .fu_cmp_res(fu_cmp_res),
        .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb),
        .wb_req(wb_req), .wb_grant(wb_grant), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign(misalign), .fu_timeout(fu_timeout), .busy(busy),
        .stat_total(stat_total), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jalr;
        logic        branch;
        logic [2:0]  cmp;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        cmp_res;
        logic [31:0] pc_jump;
        logic [31:0] pc_wb;
        int          fd;        // finish delay after fu_en+1; -1 = never
        int          gd;        // grant delay after first wb_req
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_mis;
        logic        e_wb;
        logic [31:0] e_wbdata;
        logic        e_timeout;
        int          e_idle;    // cycle (handshake = 0) at which busy is low again
        logic        e_taken;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   exp_total = 0;
    int   exp_taken = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef JUMP_STATS_EN
        chk({tag, "_stat_total"}, stat_total, 32'(exp_total));
        chk({tag, "_stat_taken"}, stat_taken, 32'(exp_taken));
`else
        chk({tag, "_stat_total"}, stat_total, 32'd0);
        chk({tag, "_stat_taken"}, stat_taken, 32'd0);
`endif
    endtask

    // Drives the handshake; returns at the negedge of the ISSUE cycle.
    task automatic start(input vec_t v);
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_jalr     = v.jalr;
        issue_branch   = v.branch;
        issue_cmp_ctrl = v.cmp;
        issue_rd       = v.rd;
        issue_rs1      = v.rs1;
        issue_rs2      = v.rs2;
        issue_imm      = v.imm;
        issue_pc       = v.pc;
        fu_finish      = 1'b0;
        wb_grant       = 1'b0;
        flush          = 1'b0;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    // Observes n cycles and requires no redirect, misalign, wb_req or timeout.
    task automatic watch_quiet(input string name, input int n);
        int ev = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            ev += int'(redirect_valid) + int'(misalign) + int'(wb_req) + int'(fu_timeout);
            @(negedge clk);
        end
        chk(name, 32'(ev), 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int en_cyc = -1, en_cnt = 0, rd_cnt = 0, rd_cyc = -1, mis_cnt = 0;
        int to_cnt = 0, to_cyc = -1, wb_cnt = 0, wb_first = -1, wb_unstable = 0, idle = -1;
        logic [31:0] rpc = 32'd0, wbd = 32'd0;
        logic [4:0]  wbr = 5'd0;
        logic [31:0] o_pc = 32'd0, o_imm = 32'd0, o_rs1 = 32'd0, o_rs2 = 32'd0;
        logic [3:0]  o_ctl = 4'd0;
        string t;
        t = $sformatf("v%0d", idx);

        @(negedge clk);
        issue_valid    = 1'b1;
        issue_jalr     = v.jalr;
        issue_branch   = v.branch;
        issue_cmp_ctrl = v.cmp;
        issue_rd       = v.rd;
        issue_rs1      = v.rs1;
        issue_rs2      = v.rs2;
        issue_imm      = v.imm;
        issue_pc       = v.pc;
        fu_finish      = 1'b0;
        wb_grant       = 1'b0;
        #1;
        chk({t, "_issue_ready"}, {31'd0, issue_ready}, 32'd1);
        @(posedge clk);

        for (int c = 1; c <= 40 && idle < 0; c++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            wb_grant    = 1'b0;
            fu_finish   = (v.fd >= 0 && en_cyc >= 0 && c == en_cyc + 1 + v.fd);
            fu_cmp_res  = fu_finish ? v.cmp_res : 1'b0;
            fu_pc_jump  = fu_finish ? v.pc_jump : 32'd0;
            fu_pc_wb    = fu_finish ? v.pc_wb : 32'd0;
            #1;
            if (fu_en) begin
                en_cnt++;
                if (en_cyc < 0) en_cyc = c;
            end
            if (c == 2) begin
                o_pc  = fu_pc;
                o_imm = fu_imm;
                o_rs1 = fu_rs1;
                o_rs2 = fu_rs2;
                o_ctl = {fu_jalr, fu_cmp_ctrl};
            end
            if (redirect_valid) begin
                rd_cnt++;
                rd_cyc = c;
                rpc    = redirect_pc;
            end
            if (misalign) mis_cnt++;
            if (fu_timeout) begin
                to_cnt++;
                to_cyc = c;
            end
            if (wb_req) begin
                if (wb_first < 0) begin
                    wb_first = c;
                    wbd      = wb_data;
                    wbr      = wb_rd;
                end else if (wb_data !== wbd || wb_rd !== wbr) begin
                    wb_unstable++;
                end
                wb_cnt++;
                wb_grant = (c - wb_first >= v.gd);
            end
            if (!busy) idle = c;
            @(posedge clk);
        end
        @(negedge clk);
        fu_finish = 1'b0;
        wb_grant  = 1'b0;

        chk({t, "_idle_cycle"}, 32'(idle), 32'(v.e_idle));
        chk({t, "_fu_en_cycle"}, 32'(en_cyc), 32'd1);
        chk({t, "_fu_en_count"}, 32'(en_cnt), 32'd1);
        chk({t, "_fu_pc"}, o_pc, v.pc);
        chk({t, "_fu_imm"}, o_imm, v.imm);
        chk({t, "_fu_rs1"}, o_rs1, v.rs1);
        chk({t, "_fu_rs2"}, o_rs2, v.rs2);
        chk({t, "_fu_ctl"}, {28'd0, o_ctl}, {28'd0, v.jalr, v.cmp});
        chk({t, "_redirect_count"}, 32'(rd_cnt), {31'd0, v.e_redir});
        if (v.e_redir) begin
            chk({t, "_redirect_cycle"}, 32'(rd_cyc), 32'(3 + v.fd));
            chk({t, "_redirect_pc"}, rpc, v.e_rpc);
        end
        chk({t, "_misalign_count"}, 32'(mis_cnt), {31'd0, v.e_mis});
        chk({t, "_timeout_count"}, 32'(to_cnt), {31'd0, v.e_timeout});
        if (v.e_timeout) chk({t, "_timeout_cycle"}, 32'(to_cyc), 32'(v.e_idle - 1));
        chk({t, "_wb_req_cycles"}, 32'(wb_cnt), v.e_wb ? 32'(v.gd + 1) : 32'd0);
        if (v.e_wb) begin
            chk({t, "_wb_first"}, 32'(wb_first), 32'(4 + v.fd));
            chk({t, "_wb_data"}, wbd, v.e_wbdata);
            chk({t, "_wb_rd"}, {27'd0, wbr}, {27'd0, v.rd});
            chk({t, "_wb_stable"}, 32'(wb_unstable), 32'd0);
        end
        if (!v.e_timeout) begin
            exp_total++;
            exp_taken += int'(v.e_taken);
        end
        chk_stats(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //         jalr  br    cmp   rd     rs1      rs2      imm        pc         cres  pc_jump    pc_wb     fd  gd  redir rpc        mis   wb    wbdata     to    idle taken
        vecs[0] = '{1'b0, 1'b0, 3'd0, 5'd1, 32'd0,   32'd0,   32'h20,    32'h100,   1'b0, 32'h120,   32'h104,  0,  0,  1'b1, 32'h120,   1'b0, 1'b1, 32'h104,   1'b0, 5,   1'b1};
        vecs[1] = '{1'b0, 1'b1, 3'd0, 5'd4, 32'd5,   32'd6,   32'h40,    32'h200,   1'b0, 32'h240,   32'h204,  0,  0,  1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 4,   1'b0};
        vecs[2] = '{1'b1, 1'b0, 3'd0, 5'd1, 32'h200, 32'd0,   32'h3,     32'h300,   1'b0, 32'h203,   32'h304,  0,  0,  1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     1'b0, 4,   1'b1};
        vecs[3] = '{1'b0, 1'b0, 3'd0, 5'd5, 32'd0,   32'd0,   32'h100,   32'h300,   1'b0, 32'h400,   32'h304,  0,  5,  1'b1, 32'h400,   1'b0, 1'b1, 32'h304,   1'b0, 10,  1'b1};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 5'd7, 32'd0,   32'd0,   32'h8,     32'h500,   1'b0, 32'h508,   32'h504,  -1, 0,  1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     1'b1, 6,   1'b0};
        vecs[5] = '{1'b0, 1'b1, 3'd1, 5'd4, 32'd1,   32'd2,   32'hc00,   32'h400,   1'b1, 32'h1000,  32'h404,  0,  0,  1'b1, 32'h1000,  1'b0, 1'b0, 32'h0,     1'b0, 4,   1'b1};
        vecs[6] = '{1'b1, 1'b0, 3'd0, 5'd2, 32'h301, 32'd0,   32'd0,     32'h84,    1'b0, 32'h301,   32'h88,   0,  0,  1'b1, 32'h300,   1'b0, 1'b1, 32'h88,    1'b0, 5,   1'b1};
        vecs[7] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'd0,   32'd0,   32'h10,    32'h40,    1'b0, 32'h50,    32'h44,   0,  0,  1'b1, 32'h50,    1'b0, 1'b0, 32'h0,     1'b0, 4,   1'b1};
        vecs[8] = '{1'b0, 1'b0, 3'd0, 5'd3, 32'd0,   32'd0,   32'h30,    32'h600,   1'b0, 32'h630,   32'h604,  2,  1,  1'b1, 32'h630,   1'b0, 1'b1, 32'h604,   1'b0, 8,   1'b1};

        // Reset values
        #12;
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {28'd0, fu_en, redirect_valid, misalign, fu_timeout}, 32'd0);
        chk("rst_wb", {26'd0, wb_req, wb_rd}, 32'd0);
        chk("rst_fu_pc", fu_pc, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // fu_finish while idle is ignored
        @(negedge clk);
        fu_finish = 1'b1;
        @(negedge clk);
        fu_finish = 1'b0;
        #1;
        chk("idle_finish_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        watch_quiet("idle_finish_quiet", 3);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // Flush while in ISSUE: DRAIN absorbs the finish, then IDLE, no outputs
        start(vecs[0]);
        #1;
        chk("flush_issue_fu_en", {31'd0, fu_en}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_drain_busy", {30'd0, busy, fu_en}, 32'd2);
        fu_finish  = 1'b1;
        fu_pc_jump = 32'h120;
        fu_pc_wb   = 32'h104;
        @(negedge clk);
        fu_finish = 1'b0;
        #1;
        chk("flush_drain_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        watch_quiet("flush_issue_quiet", 4);
        chk_stats("flush_issue");
        run_txn(vecs[0], 100);

        // Flush coinciding with finish in WAIT: straight to IDLE, results dropped
        start(vecs[0]);
        @(negedge clk);
        flush      = 1'b1;
        fu_finish  = 1'b1;
        fu_pc_jump = 32'h120;
        fu_pc_wb   = 32'h104;
        @(negedge clk);
        flush     = 1'b0;
        fu_finish = 1'b0;
        #1;
        chk("flush_wait_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        watch_quiet("flush_wait_quiet", 4);
        chk_stats("flush_wait");

        // Flush coinciding with grant in WB: write done, IDLE, no further wb_req
        start(vecs[0]);
        @(negedge clk);
        fu_finish  = 1'b1;
        fu_cmp_res = 1'b0;
        fu_pc_jump = 32'h120;
        fu_pc_wb   = 32'h104;
        @(negedge clk);
        fu_finish = 1'b0;
        #1;
        chk("flush_wb_redirect", {31'd0, redirect_valid}, 32'd1);
        exp_total++;
        exp_taken++;
        @(negedge clk);
        #1;
        chk("flush_wb_req", {31'd0, wb_req}, 32'd1);
        flush    = 1'b1;
        wb_grant = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        wb_grant = 1'b0;
        #1;
        chk("flush_wb_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        watch_quiet("flush_wb_quiet", 3);
        chk_stats("flush_wb");

        // Reset in WAIT aborts without pulses; next issue completes
        start(vecs[0]);
        @(negedge clk);
        rst_n = 1'b0;
        exp_total = 0;
        exp_taken = 0;
        #1;
        chk("midrst_busy", {30'd0, busy, issue_ready}, 32'd1);
        chk("midrst_fu_pc", fu_pc, 32'd0);
        chk_stats("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("midrst_quiet", 3);
        run_txn(vecs[0], 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
